// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog controller.
// Holds the FSM state encoding and the sizing for the reset-pulse counter.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WARN = 2'd2,
        BITE = 2'd3
    } wdt_state_e;

    localparam int unsigned DEF_RST_PULSE_CYCLES = 4;
    localparam int unsigned PULSE_CNT_WIDTH      = $clog2(DEF_RST_PULSE_CYCLES + 1);

    // Lets the top size its pulse counter for a non-default pulse length.
    function automatic int unsigned pulse_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Clock prescaler for the watchdog: counts 0..n and emits a one-cycle tick on wrap.
// A clear forces the count back to 0 and suppresses the tick for that cycle.
module wdt_prescaler
    import wdt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             clear,
    input  logic [WIDTH-1:0] n,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap;

    assign wrap = (cnt_q >= n);
    assign tick = wrap && !clear;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog controller: config shadows, two-key kick decoder, prescaled down-counter,
// warning interrupt and a fixed-length active-low reset pulse on expiry.
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter int unsigned          COUNTER_WIDTH    = 16,
    parameter int unsigned          PRESCALE_WIDTH   = 8,
    parameter int unsigned          KEY_WIDTH        = 16,
    parameter logic [KEY_WIDTH-1:0] KICK_KEY1        = 16'h5555,
    parameter logic [KEY_WIDTH-1:0] KICK_KEY2        = 16'hAAAA,
    parameter int unsigned          RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic                      en,
    input  logic                      cfg_load,
    input  logic [COUNTER_WIDTH-1:0]  cfg_timeout,
    input  logic [COUNTER_WIDTH-1:0]  cfg_warn,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      kick_valid,
    input  logic [KEY_WIDTH-1:0]      kick_data,
    output logic [COUNTER_WIDTH-1:0]  count,
    output logic [1:0]                state,
    output logic                      warn_irq,
    output logic                      kick_err,
    output logic                      wdt_rst_b
);

    localparam int unsigned    PW         = pulse_cnt_width(RST_PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);

    wdt_state_e                state_q, state_d;
    logic [COUNTER_WIDTH-1:0]  count_q, count_d;
    logic [COUNTER_WIDTH-1:0]  sh_timeout_q, sh_timeout_d;
    logic [COUNTER_WIDTH-1:0]  sh_warn_q, sh_warn_d;
    logic [PRESCALE_WIDTH-1:0] sh_prescale_q, sh_prescale_d;
    logic                      armed_q, armed_d;
    logic                      kick_err_q, kick_err_d;
    logic                      rst_b_q, rst_b_d;
    logic [PW-1:0]             pulse_q, pulse_d;

    logic [COUNTER_WIDTH-1:0]  eff_timeout;
    logic                      active;
    logic                      kick_done;
    logic                      presc_clear;
    logic                      tick;

    // A zero timeout would bite with no warning at all, so it behaves as one tick.
    assign eff_timeout = (sh_timeout_q == '0) ? COUNTER_WIDTH'(1) : sh_timeout_q;
    assign active      = (state_q == RUN) || (state_q == WARN);
    assign kick_done   = active && en && kick_valid && (kick_data == KICK_KEY2) && armed_q;
    assign presc_clear = (state_q == IDLE) || (state_q == BITE) || kick_done;

    wdt_prescaler #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_b (reset_b),
        .clear   (presc_clear),
        .n       (sh_prescale_q),
        .tick    (tick)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        sh_timeout_d  = sh_timeout_q;
        sh_warn_d     = sh_warn_q;
        sh_prescale_d = sh_prescale_q;
        armed_d       = armed_q;
        kick_err_d    = 1'b0;
        rst_b_d       = 1'b1;
        pulse_d       = pulse_q;

        case (state_q)
            IDLE: begin
                armed_d = 1'b0;
                if (cfg_load) begin
                    sh_timeout_d  = cfg_timeout;
                    sh_warn_d     = cfg_warn;
                    sh_prescale_d = cfg_prescale;
                end
                if (en) begin
                    state_d = RUN;
                    count_d = eff_timeout;
                end
            end
            RUN, WARN: begin
                if (!en) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else if (kick_done) begin
                    // A completing kick beats a terminal tick in the same cycle.
                    state_d = RUN;
                    count_d = eff_timeout;
                    armed_d = 1'b0;
                end else begin
                    if (kick_valid) begin
                        if (kick_data == KICK_KEY1) begin
                            armed_d = 1'b1;
                        end else begin
                            kick_err_d = 1'b1;
                            armed_d    = 1'b0;
                        end
                    end
                    if (tick && (count_q != '0)) begin
                        count_d = count_q - 1'b1;
                    end
                    if (tick && (count_q == COUNTER_WIDTH'(1))) begin
                        state_d = BITE;
                        pulse_d = '0;
                        rst_b_d = 1'b0;
                    end else if ((state_q == RUN) && (count_d <= sh_warn_q)) begin
                        state_d = WARN;
                    end
                end
            end
            BITE: begin
                armed_d = 1'b0;
                if (pulse_q == PULSE_LAST) begin
                    count_d = eff_timeout;
                    state_d = en ? RUN : IDLE;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                    rst_b_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= IDLE;
            count_q       <= '0;
            sh_timeout_q  <= '0;
            sh_warn_q     <= '0;
            sh_prescale_q <= '0;
            armed_q       <= 1'b0;
            kick_err_q    <= 1'b0;
            rst_b_q       <= 1'b1;
            pulse_q       <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            sh_timeout_q  <= sh_timeout_d;
            sh_warn_q     <= sh_warn_d;
            sh_prescale_q <= sh_prescale_d;
            armed_q       <= armed_d;
            kick_err_q    <= kick_err_d;
            rst_b_q       <= rst_b_d;
            pulse_q       <= pulse_d;
        end
    end

    assign count     = count_q;
    assign state     = state_q;
    assign warn_irq  = (state_q == WARN);
    assign kick_err  = kick_err_q;
    assign wdt_rst_b = rst_b_q;

endmodule
